// File: rtl/minibot_pkg.sv
// Shared types and helpers for the minibot motion blocks.
package minibot_pkg;

  localparam int unsigned DefaultSampleCycles = 50000;
  localparam int unsigned DefaultSpeedW       = 16;

  typedef logic signed [DefaultSpeedW-1:0] speed_t;
  typedef logic [31:0]                     pos_count_t;

  // Clamp a signed 32-bit value into the range of a signed width-bit number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int unsigned width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = 32'sh7fff_ffff >>> (32 - width);
    lo = ~hi;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/sample_timer.sv
// Free-running window timer: pulses tick on the last cycle of each PERIOD-cycle window.
module sample_timer #(
  parameter int unsigned PERIOD = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned TimerW = $clog2(PERIOD);
  localparam logic [TimerW-1:0] Last = TimerW'(PERIOD - 1);

  logic [TimerW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = '0;
    tick    = 1'b0;
    if (enable) begin
      tick    = (timer_q == Last);
      timer_d = tick ? '0 : timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/speed_estimator.sv
// Windowed speed estimate from a wrapping position count: raw delta plus moving average.
module speed_estimator
  import minibot_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = DefaultSampleCycles,
  parameter int unsigned LOG2_AVG      = 2,
  parameter int unsigned SPEED_W       = DefaultSpeedW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  pos_count_t                counter,
  input  logic                      clear_overflow,
  output logic signed [SPEED_W-1:0] speed_raw,
  output logic signed [SPEED_W-1:0] speed,
  output logic                      speed_valid,
  output logic                      overflow
);

  localparam int unsigned IdxW   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned HistN  = 1 << IdxW;
  localparam int unsigned SumW   = SPEED_W + LOG2_AVG;

  logic                      tick;
  logic                      primed_q;
  pos_count_t                prev_q;
  logic signed [SPEED_W-1:0] raw_q;
  logic                      upd_q;
  logic                      avg_q;
  logic                      valid_q;
  logic signed [SPEED_W-1:0] hist_q [HistN];
  logic signed [SumW-1:0]    sum_q;
  logic signed [SumW-1:0]    sum_d;
  logic [IdxW-1:0]           wr_idx_q;
  logic [IdxW-1:0]           wr_idx_nxt;
  logic signed [SPEED_W-1:0] speed_q;
  logic                      ovf_q;

  logic signed [31:0] delta;
  logic signed [31:0] delta_sat;
  logic               clamped;
  logic               ovf_set;

  sample_timer #(
    .PERIOD (SAMPLE_CYCLES)
  ) u_sample_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // Modulo subtraction read as signed gives the right delta across counter wrap.
  always_comb begin
    delta      = $signed(counter - prev_q);
    delta_sat  = sat_signed(delta, SPEED_W);
    clamped    = (delta_sat != delta);
    ovf_set    = enable && tick && primed_q && clamped;
    sum_d      = sum_q + SumW'(raw_q) - SumW'(hist_q[wr_idx_q]);
    wr_idx_nxt = (LOG2_AVG == 0) ? '0 : wr_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      primed_q <= 1'b0;
      prev_q   <= '0;
      raw_q    <= '0;
      upd_q    <= 1'b0;
      avg_q    <= 1'b0;
      valid_q  <= 1'b0;
      hist_q   <= '{default: '0};
      sum_q    <= '0;
      wr_idx_q <= '0;
      speed_q  <= '0;
    end else begin
      upd_q   <= 1'b0;
      avg_q   <= upd_q;
      valid_q <= avg_q;
      if (tick) begin
        prev_q <= counter;
        if (!primed_q) begin
          primed_q <= 1'b1;
        end else begin
          raw_q <= delta_sat[SPEED_W-1:0];
          upd_q <= 1'b1;
        end
      end
      if (upd_q) begin
        sum_q            <= sum_d;
        hist_q[wr_idx_q] <= raw_q;
        wr_idx_q         <= wr_idx_nxt;
      end
      // Taking the top SPEED_W bits is the arithmetic shift right by LOG2_AVG.
      if (avg_q) begin
        speed_q <= sum_q[SumW-1:LOG2_AVG];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (clear_overflow) begin
      ovf_q <= 1'b0;
    end
  end

  assign speed_raw   = raw_q;
  assign speed       = speed_q;
  assign speed_valid = valid_q;
  assign overflow    = ovf_q;

endmodule
